// File: rtl/ftdi_pkg.sv
// Shared types and default timing for the FT232H 245-FIFO sequencer.
//   state_t : bus sequencer states
//   grant_t : which path owns the bus for the current transaction
package ftdi_pkg;

   localparam int unsigned RD_PULSE_DEF = 3;
   localparam int unsigned WR_PULSE_DEF = 3;
   localparam int unsigned SETUP_DEF    = 1;
   localparam int unsigned RECOVERY_DEF = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_STROBE = 3'd1,
      WR_SETUP  = 3'd2,
      WR_STROBE = 3'd3,
      WR_HOLD   = 3'd4,
      RECOVER   = 3'd5
   } state_t;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } grant_t;

   // Larger of two timing parameters; used to size the shared down-counter.
   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous active-low FTDI status flags.
// Flops reset to all ones so the flags read as inactive out of reset.
//   clock   : destination clock
//   reset_n : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronised output
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ftdi_fifo_sequencer.sv
// FT232H asynchronous 245-FIFO bus sequencer. Shares the half-duplex ADBUS
// between the host->FPGA read path and the FPGA->host write path with
// round-robin arbitration, and generates RD#/WR# strobes with fixed timing.
//   clock, reset_n        : 50 MHz clock, asynchronous active-low reset
//   en                    : gates the start of new transactions
//   rxf_n, txe_n          : FTDI status flags (asynchronous, active low)
//   adbus_in/out/tri      : pin-level byte bus; adbus_tri=1 means FPGA drives
//   ftdi_rd_n, ftdi_wr_n  : FTDI strobes
//   rx_data/valid/ready   : 1-entry holding register toward the core
//   tx_data/valid/ready   : byte from the core; tx_ready pulses on capture
//   busy                  : sequencer not in IDLE
module ftdi_fifo_sequencer
   import ftdi_pkg::*;
#(
   parameter int unsigned RD_PULSE_CYCLES = RD_PULSE_DEF,
   parameter int unsigned WR_PULSE_CYCLES = WR_PULSE_DEF,
   parameter int unsigned SETUP_CYCLES    = SETUP_DEF,
   parameter int unsigned RECOVERY_CYCLES = RECOVERY_DEF
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       en,
   input  logic       rxf_n,
   input  logic       txe_n,
   input  logic [7:0] adbus_in,
   output logic [7:0] adbus_out,
   output logic       adbus_tri,
   output logic       ftdi_rd_n,
   output logic       ftdi_wr_n,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy
);

   localparam int unsigned MAX_CYCLES = max2(max2(RD_PULSE_CYCLES, WR_PULSE_CYCLES),
                                             max2(SETUP_CYCLES, RECOVERY_CYCLES));
   localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1);

   // Counter reload values: a phase of N cycles loads N-1 and ends at 0.
   localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(RD_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WR_LOAD    = CNT_W'(WR_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] REC_LOAD   = CNT_W'(RECOVERY_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   grant_t           last_grant_q, last_grant_d;

   logic [1:0] flags_s;
   logic       rxf_s, txe_s;
   logic       rd_ok, wr_ok, grant_rd, grant_wr, cnt_zero;

   logic rd_n_d, wr_n_d, tri_d, busy_d, tx_capture, rx_capture;

   sync_2ff #(.WIDTH(2)) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       ({rxf_n, txe_n}),
      .q       (flags_s)
   );

   assign rxf_s = flags_s[1];
   assign txe_s = flags_s[0];

   // A read needs an empty holding register; that is the backpressure path.
   assign rd_ok    = en & ~rxf_s & ~rx_valid;
   assign wr_ok    = en & ~txe_s & tx_valid;
   assign grant_rd = rd_ok & (~wr_ok | (last_grant_q == WRITE));
   assign grant_wr = wr_ok & ~grant_rd;
   assign cnt_zero = (cnt_q == '0);

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= WRITE;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state and timing counter.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (grant_rd) begin
               state_d      = RD_STROBE;
               cnt_d        = RD_LOAD;
               last_grant_d = READ;
            end else if (grant_wr) begin
               state_d      = WR_SETUP;
               cnt_d        = SETUP_LOAD;
               last_grant_d = WRITE;
            end
         end
         RD_STROBE: begin
            if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
            else begin
               state_d = RECOVER;
               cnt_d   = REC_LOAD;
            end
         end
         WR_SETUP: begin
            if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
            else begin
               state_d = WR_STROBE;
               cnt_d   = WR_LOAD;
            end
         end
         WR_STROBE: begin
            if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
            else begin
               state_d = WR_HOLD;
               cnt_d   = '0;
            end
         end
         WR_HOLD: begin
            state_d = RECOVER;
            cnt_d   = REC_LOAD;
         end
         RECOVER: begin
            if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
            else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode from the next state, so pins are registered and aligned
   // with the state they belong to.
   always_comb begin
      rd_n_d     = 1'b1;
      wr_n_d     = 1'b1;
      tri_d      = 1'b0;
      busy_d     = 1'b0;
      tx_capture = 1'b0;
      rx_capture = 1'b0;
      rd_n_d     = (state_d != RD_STROBE);
      wr_n_d     = (state_d != WR_STROBE);
      tri_d      = (state_d == WR_SETUP) || (state_d == WR_STROBE) || (state_d == WR_HOLD);
      busy_d     = (state_d != IDLE);
      tx_capture = (state_q == IDLE) && grant_wr;
      rx_capture = (state_q == RD_STROBE) && cnt_zero;
   end

   // Output registers; reset releases the bus and strobes immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ftdi_rd_n <= 1'b1;
         ftdi_wr_n <= 1'b1;
         adbus_tri <= 1'b0;
         adbus_out <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_ready  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         ftdi_rd_n <= rd_n_d;
         ftdi_wr_n <= wr_n_d;
         adbus_tri <= tri_d;
         tx_ready  <= tx_capture;
         busy      <= busy_d;
         if (tx_capture) adbus_out <= tx_data;
         if (rx_capture) rx_data <= adbus_in;
         if (rx_capture)    rx_valid <= 1'b1;
         else if (rx_ready) rx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ftdi_fifo_sequencer.sv
// Directed bench for ftdi_fifo_sequencer with hand-computed expectations.
module tb_ftdi_fifo_sequencer;

   logic       clock = 1'b0;
   logic       reset_n, en, rxf_n, txe_n, rx_ready, tx_valid;
   logic [7:0] adbus_in, tx_data;
   logic [7:0] adbus_out, rx_data;
   logic       adbus_tri, ftdi_rd_n, ftdi_wr_n, rx_valid, tx_ready, busy;

   int errors = 0;
   int checks = 0;

   ftdi_fifo_sequencer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .en        (en),
      .rxf_n     (rxf_n),
      .txe_n     (txe_n),
      .adbus_in  (adbus_in),
      .adbus_out (adbus_out),
      .adbus_tri (adbus_tri),
      .ftdi_rd_n (ftdi_rd_n),
      .ftdi_wr_n (ftdi_wr_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy)
   );

   always #10 clock = ~clock;

   // Mid-cycle bus monitor: strobe counts, pulse lengths, grant order.
   int   rd_falls = 0, wr_falls = 0, txr_pulses = 0, overlap_cnt = 0;
   int   rd_len_run = 0, rd_len_last = 0, rd_hi_run = 0, rd_hi_last = 0;
   int   wr_len_run = 0, wr_len_last = 0;
   logic prev_rd_n = 1'b1, prev_wr_n = 1'b1;
   bit   grant_log[$];

   always @(negedge clock) begin
      if (!ftdi_rd_n && adbus_tri) overlap_cnt++;
      if (tx_ready) begin
         txr_pulses++;
         grant_log.push_back(1'b1);
      end
      if (!ftdi_rd_n) begin
         if (prev_rd_n) begin
            rd_falls++;
            grant_log.push_back(1'b0);
            rd_hi_last = rd_hi_run;
            rd_hi_run  = 0;
         end
         rd_len_run++;
      end else begin
         if (!prev_rd_n) begin
            rd_len_last = rd_len_run;
            rd_len_run  = 0;
         end
         rd_hi_run++;
      end
      if (!ftdi_wr_n) begin
         if (prev_wr_n) wr_falls++;
         wr_len_run++;
      end else if (!prev_wr_n) begin
         wr_len_last = wr_len_run;
         wr_len_run  = 0;
      end
      prev_rd_n = ftdi_rd_n;
      prev_wr_n = ftdi_wr_n;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_rx_valid(input string tag, input int lim);
      int n = 0;
      while (!rx_valid && n < lim) begin tick(); n++; end
      check(tag, 32'(rx_valid), 1);
   endtask

   task automatic wait_tx_ready(input string tag, input int lim);
      int n = 0;
      while (!tx_ready && n < lim) begin tick(); n++; end
      check(tag, 32'(tx_ready), 1);
   endtask

   task automatic wait_idle(input string tag, input int lim);
      int n = 0;
      while (busy && n < lim) begin tick(); n++; end
      check(tag, 32'(busy), 0);
   endtask

   task automatic wait_rd_low(input string tag, input int lim);
      int n = 0;
      while (ftdi_rd_n && n < lim) begin tick(); n++; end
      check(tag, 32'(ftdi_rd_n), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s_rd, s_wr, s_tx, g0, idx, n;
      reset_n = 1'b1; en = 1'b1; rxf_n = 1'b1; txe_n = 1'b1;
      adbus_in = 8'h00; rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
      #2 reset_n = 1'b0;
      #3;
      check("rst_rd_n", 32'(ftdi_rd_n), 1);
      check("rst_wr_n", 32'(ftdi_wr_n), 1);
      check("rst_tri", 32'(adbus_tri), 0);
      check("rst_adbus_out", 32'(adbus_out), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      check("rst_tx_ready", 32'(tx_ready), 0);
      check("rst_busy", 32'(busy), 0);
      tick(); tick();
      reset_n = 1'b1;
      tick();

      // Read only, no consumer
      adbus_in = 8'hA5; rxf_n = 1'b0; s_rd = rd_falls;
      wait_rx_valid("rd1_valid_timeout", 40);
      tick();
      check("rd1_pulse_len", 32'(rd_len_last), 3);
      check("rd1_data", 32'(rx_data), 32'h A5);
      check("rd1_valid", 32'(rx_valid), 1);
      repeat (30) tick();
      check("rd1_backpressure", 32'(rd_falls - s_rd), 1);
      adbus_in = 8'h5A; rx_ready = 1'b1; tick(); rx_ready = 1'b0;
      check("rx_valid_clear", 32'(rx_valid), 0);
      wait_rx_valid("rd2_valid_timeout", 40);
      check("rd2_data", 32'(rx_data), 32'h5A);
      // Consume right away: next strobe still waits out RECOVER plus IDLE
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
      wait_rx_valid("rd3_valid_timeout", 40);
      check("rd_recovery_gap", 32'(rd_hi_last), 5);
      rxf_n = 1'b1; rx_ready = 1'b1; tick(); rx_ready = 1'b0;
      wait_idle("rd_idle_timeout", 20);

      // Write only
      tx_data = 8'h3C; tx_valid = 1'b1; txe_n = 1'b0;
      s_wr = wr_falls; s_tx = txr_pulses;
      wait_tx_ready("wr_ready_timeout", 20);
      check("wr_setup_tri", 32'(adbus_tri), 1);
      check("wr_setup_data", 32'(adbus_out), 32'h3C);
      check("wr_setup_wr_n", 32'(ftdi_wr_n), 1);
      tx_valid = 1'b0; tx_data = 8'h00;
      tick();
      check("wr_ready_pulse", 32'(tx_ready), 0);
      check("wr_strobe_fall", 32'(ftdi_wr_n), 0);
      tick(); tick();
      check("wr_strobe_third", 32'(ftdi_wr_n), 0);
      tick();
      check("wr_hold_wr_n", 32'(ftdi_wr_n), 1);
      check("wr_hold_tri", 32'(adbus_tri), 1);
      check("wr_hold_data", 32'(adbus_out), 32'h3C);
      tick();
      check("wr_release_tri", 32'(adbus_tri), 0);
      wait_idle("wr_idle_timeout", 20);
      check("wr_pulse_len", 32'(wr_len_last), 3);
      check("wr_strobe_count", 32'(wr_falls - s_wr), 1);
      check("wr_ready_count", 32'(txr_pulses - s_tx), 1);

      // TXE# full holds the write off
      txe_n = 1'b1; repeat (3) tick();
      tx_data = 8'h96; tx_valid = 1'b1; s_wr = wr_falls; s_tx = txr_pulses;
      repeat (20) tick();
      check("txe_full_no_strobe", 32'(wr_falls - s_wr), 0);
      check("txe_full_no_ready", 32'(txr_pulses - s_tx), 0);
      txe_n = 1'b0; n = 0;
      while (!tx_ready && n < 20) begin tick(); n++; end
      check("txe_latency", 32'(n), 3);
      tx_valid = 1'b0;
      wait_idle("txe_idle_timeout", 20);

      // Contention with consumer always ready
      txe_n = 1'b1; repeat (4) tick();
      adbus_in = 8'h77; tx_data = 8'h01; tx_valid = 1'b1; rx_ready = 1'b1;
      rxf_n = 1'b0; txe_n = 1'b0; g0 = grant_log.size(); idx = 0; n = 0;
      while (idx < 4 && n < 300) begin
         tick(); n++;
         if (tx_ready) begin
            check("cont_tx_byte", 32'(adbus_out), 32'(idx + 1));
            idx++;
            if (idx == 4) begin
               tx_valid = 1'b0; rxf_n = 1'b1;
            end else begin
               tx_data = 8'(idx + 1);
            end
         end
      end
      check("cont_writes", 32'(idx), 4);
      wait_idle("cont_idle_timeout", 40);
      rx_ready = 1'b0;
      check("cont_grant_count", 32'(grant_log.size() - g0), 8);
      for (int i = 0; i < 8; i++) begin
         if (g0 + i < grant_log.size())
            check("cont_grant_order", 32'(grant_log[g0 + i]), 32'(i % 2));
      end
      check("cont_rx_data", 32'(rx_data), 32'h77);

      // Asynchronous reset in the middle of WR_STROBE
      tx_data = 8'hC3; tx_valid = 1'b1;
      wait_tx_ready("arst_ready_timeout", 20);
      tx_valid = 1'b0;
      tick();
      check("arst_pre_wr_n", 32'(ftdi_wr_n), 0);
      #3 reset_n = 1'b0;
      #1;
      check("arst_wr_n", 32'(ftdi_wr_n), 1);
      check("arst_tri", 32'(adbus_tri), 0);
      check("arst_busy", 32'(busy), 0);
      tick(); tick();
      reset_n = 1'b1;
      g0 = grant_log.size();
      adbus_in = 8'h4B; rxf_n = 1'b0; tx_data = 8'hD2; tx_valid = 1'b1;
      n = 0;
      while (grant_log.size() == g0 && n < 30) begin tick(); n++; end
      check("arst_first_grant", (grant_log.size() > g0) ? 32'(grant_log[g0]) : 32'd1, 0);
      rxf_n = 1'b1;
      wait_tx_ready("arst_wr_timeout", 40);
      tx_valid = 1'b0;
      wait_idle("arst_idle_timeout", 40);
      check("arst_rx_data", 32'(rx_data), 32'h4B);
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;

      // Enable gating
      en = 1'b0; rxf_n = 1'b0; adbus_in = 8'hE1; s_rd = rd_falls; s_wr = wr_falls;
      repeat (20) tick();
      check("en_off_no_rd", 32'(rd_falls - s_rd), 0);
      check("en_off_no_wr", 32'(wr_falls - s_wr), 0);
      check("en_off_busy", 32'(busy), 0);
      en = 1'b1;
      wait_rd_low("en_rd_timeout", 20);
      en = 1'b0;
      wait_rx_valid("en_valid_timeout", 20);
      tick();
      check("en_drop_pulse_len", 32'(rd_len_last), 3);
      check("en_drop_data", 32'(rx_data), 32'hE1);
      repeat (20) tick();
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
      repeat (20) tick();
      check("en_drop_single_rd", 32'(rd_falls - s_rd), 1);
      check("en_drop_idle", 32'(busy), 0);

      check("rd_tri_overlap", 32'(overlap_cnt), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
